// File: rtl/fb_stream_writer_pkg.sv
// Framebuffer geometry constants and the shared address/counter types.
// Imported by the stream writer, its address map and any port-B readers.
package fb_stream_writer_pkg;

   localparam int PIXEL_WIDTH      = 64;
   localparam int PIXEL_HEIGHT     = 32;
   localparam int PIXEL_HALFHEIGHT = 16;
   localparam int BYTES_PER_PIXEL  = 2;

   localparam int AW     = $clog2(PIXEL_HEIGHT * PIXEL_WIDTH * BYTES_PER_PIXEL);
   localparam int ROW_W  = $clog2(PIXEL_HEIGHT);
   localparam int COL_W  = $clog2(PIXEL_WIDTH);
   localparam int BIDX_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;

   typedef logic [AW-1:0]     fb_addr_t;
   typedef logic [ROW_W-1:0]  row_t;
   typedef logic [ROW_W:0]    rows_t;
   typedef logic [COL_W-1:0]  col_t;
   typedef logic [BIDX_W-1:0] bidx_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

endpackage

// File: rtl/fb_stream_writer_if.sv
// Command, byte-stream, RAM port A and status signals of the stream writer.
// master = upstream/bench side, slave = the writer itself.
interface fb_stream_writer_if;
   import fb_stream_writer_pkg::*;

   logic       cmd_valid;
   row_t       cmd_row;
   rows_t      cmd_rows;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   fb_addr_t   ram_a_address;
   logic [7:0] ram_a_data_in;
   logic       ram_a_clk_enable;
   logic       ram_a_wr;
   logic       busy;
   logic       done;
   logic       err_cmd;

   modport master (
      output cmd_valid, cmd_row, cmd_rows, in_data, in_valid,
      input  in_ready, ram_a_address, ram_a_data_in, ram_a_clk_enable, ram_a_wr,
      input  busy, done, err_cmd
   );

   modport slave (
      input  cmd_valid, cmd_row, cmd_rows, in_data, in_valid,
      output in_ready, ram_a_address, ram_a_data_in, ram_a_clk_enable, ram_a_wr,
      output busy, done, err_cmd
   );

endinterface

// File: rtl/fb_stream_writer_addr_map.sv
// Raster (row,col,byte) -> interleaved framebuffer byte address; purely combinational.
// Rows of the lower panel half sit next to the same-position rows of the upper half.
module fb_stream_writer_addr_map
   import fb_stream_writer_pkg::*;
(
   input  row_t     i_row,
   input  col_t     i_col,
   input  bidx_t    i_byte,
   output fb_addr_t o_addr
);

   int w_row;
   int w_col;
   int w_byte;

   assign w_row  = int'(i_row);
   assign w_col  = int'(i_col);
   assign w_byte = int'(i_byte);

   assign o_addr = fb_addr_t'(((w_row % PIXEL_HALFHEIGHT) * PIXEL_WIDTH + w_col) * 2 * BYTES_PER_PIXEL
                              + (w_row / PIXEL_HALFHEIGHT) * BYTES_PER_PIXEL + w_byte);

endmodule

// File: rtl/fb_stream_writer.sv
// Byte-stream to framebuffer port-A writer: accepted byte appears on ram_a_* one cycle later.
// in_ready only in WRITE, so upstream stalls (never drops) while idle; one byte per clock otherwise.
module fb_stream_writer
   import fb_stream_writer_pkg::*;
(
   input logic               clk,
   input logic               reset,
   fb_stream_writer_if.slave bus
);

   localparam bidx_t BIDX_LAST = bidx_t'(BYTES_PER_PIXEL - 1);
   localparam col_t  COL_LAST  = col_t'(PIXEL_WIDTH - 1);
   localparam row_t  ROW_LAST  = row_t'(PIXEL_HEIGHT - 1);
   localparam rows_t ROWS_ONE  = rows_t'(1);

   state_t     r_state;
   state_t     w_state_nxt;
   row_t       r_row;
   col_t       r_col;
   bidx_t      r_byte;
   rows_t      r_rows_left;
   fb_addr_t   w_addr;
   fb_addr_t   r_addr;
   logic [7:0] r_data;
   logic       r_wr;
   logic       r_done_pend;
   logic       r_done;
   logic       r_err;

   logic       w_acc;
   logic       w_last;
   logic       w_row_ok;
   logic       w_load;
   logic       w_zero;
   logic       w_err_set;

   fb_stream_writer_addr_map u_addr_map (
      .i_row  (r_row),
      .i_col  (r_col),
      .i_byte (r_byte),
      .o_addr (w_addr)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_zero      = 1'b0;
      w_err_set   = 1'b0;
      w_acc       = (r_state == ST_WRITE) && bus.in_valid;
      w_last      = w_acc && (r_byte == BIDX_LAST) && (r_col == COL_LAST) && (r_rows_left == ROWS_ONE);
      w_row_ok    = int'(bus.cmd_row) < PIXEL_HEIGHT;

      case (r_state)
         ST_IDLE:  w_state_nxt = ST_IDLE;
         ST_WRITE: if (w_last) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase

      // A command always wins, also over the last byte of a running one (abort, no done).
      if (bus.cmd_valid) begin
         if (!w_row_ok) begin
            w_err_set   = 1'b1;
            w_state_nxt = ST_IDLE;
         end else if (bus.cmd_rows == '0) begin
            w_zero      = 1'b1;
            w_state_nxt = ST_IDLE;
         end else begin
            w_load      = 1'b1;
            w_state_nxt = ST_WRITE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_row       <= '0;
         r_col       <= '0;
         r_byte      <= '0;
         r_rows_left <= '0;
      end else if (w_load) begin
         r_row       <= bus.cmd_row;
         r_col       <= '0;
         r_byte      <= '0;
         r_rows_left <= bus.cmd_rows;
      end else if (w_acc) begin
         if (r_byte == BIDX_LAST) begin
            r_byte <= '0;
            if (r_col == COL_LAST) begin
               r_col       <= '0;
               r_row       <= (r_row == ROW_LAST) ? '0 : r_row + row_t'(1);
               r_rows_left <= r_rows_left - rows_t'(1);
            end else begin
               r_col <= r_col + col_t'(1);
            end
         end else begin
            r_byte <= r_byte + bidx_t'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr      <= '0;
         r_data      <= '0;
         r_wr        <= 1'b0;
         r_done_pend <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_wr <= w_acc;
         if (w_acc) begin
            r_addr <= w_addr;
            r_data <= bus.in_data;
         end
         // done trails the final write by one cycle; an empty command pulses it directly.
         r_done_pend <= w_last && !bus.cmd_valid;
         r_done      <= r_done_pend | w_zero;
         if (w_err_set) r_err <= 1'b1;
      end
   end

   assign bus.in_ready         = (r_state == ST_WRITE);
   assign bus.busy             = (r_state == ST_WRITE);
   assign bus.ram_a_address    = r_addr;
   assign bus.ram_a_data_in    = r_data;
   assign bus.ram_a_clk_enable = r_wr;
   assign bus.ram_a_wr         = r_wr;
   assign bus.done             = r_done;
   assign bus.err_cmd          = r_err;

endmodule
